ifu_fetch: RTL and testbench

Instruction fetch unit that produces the {insn, valid} stream consumed by the decode stage. It holds the fetch PC and issues one instruction-memory request at a time over a valid/ready request channel with a valid-only response channel. Fetched words go into a small queue that feeds decode through a valid/ready handshake. Redirects from execute/commit flush the queue and in-flight traffic.

---
 rtl/ifu_fetch.sv | 102 ++++++++++
 tb/tb_ifu_fetch.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the fetch PC, keeps one imem request in flight,
// and buffers returned words in a small {pc, insn} queue that feeds decode.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_insn,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_insn,
  output logic [63:0] o_pc,
  input  logic        i_ready
);

  localparam int              PW    = $clog2(QDEPTH);
  localparam int              CW    = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0]   QFULL = CW'(QDEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] insn;
  } q_ent_t;

  state_t        state, state_nxt;
  logic [63:0]   fetch_pc, req_pc;
  q_ent_t        q_mem [QDEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          req_fire, push, pop;

  // Only one request is ever in flight, so count alone bounds the issue.
  assign imem_req_valid = !reset && (state == S_REQ) && (count < QFULL);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push    = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign o_valid = (count != '0);
  assign pop     = o_valid && i_ready && !redirect_valid;
  assign o_insn  = o_valid ? q_mem[rd_ptr].insn : '0;
  assign o_pc    = o_valid ? q_mem[rd_ptr].pc   : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (req_fire) state_nxt = redirect_valid ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid)      state_nxt = S_REQ;
        else if (redirect_valid) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (imem_rsp_valid) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_REQ;
    else       state <= state_nxt;
  end

  // A redirect overrides the sequential increment even when a request fires.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~64'h3;
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + 64'd4;
      req_pc   <= fetch_pc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) q_mem[i] <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_mem[wr_ptr] <= '{pc: req_pc, insn: imem_rsp_insn};
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed cycle table, reset-in-flight sequence, then
// randomized memory/decode/redirect traffic checked against a stream model.
module tb_ifu_fetch;

  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clock, reset;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_insn;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        o_valid;
  logic [31:0] o_insn;
  logic [63:0] o_pc;
  logic        i_ready;

  ifu_fetch #(.RESET_PC(RPC), .QDEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_insn(imem_rsp_insn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .o_valid(o_valid), .o_insn(o_insn), .o_pc(o_pc), .i_ready(i_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        rdy, rsp;
    logic [31:0] rinsn;
    logic        redir;
    logic [63:0] rpc;
    logic        irdy;
    logic        ev;
    logic [63:0] ea;
    logic        eov;
    logic [63:0] epc;
    logic [31:0] eins;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic add(input logic rdy, input logic rsp, input logic [31:0] ri,
                     input logic rd, input logic [63:0] rp, input logic ir,
                     input logic ev, input logic [63:0] ea, input logic eov,
                     input logic [63:0] epc, input logic [31:0] eins);
    vec_t v;
    v.rdy = rdy; v.rsp = rsp; v.rinsn = ri; v.redir = rd; v.rpc = rp; v.irdy = ir;
    v.ev = ev; v.ea = ea; v.eov = eov; v.epc = epc; v.eins = eins;
    vq.push_back(v);
  endtask

  // Memory contents as a function of address so any word/PC mispairing shows.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic drive(input logic rdy, input logic rsp, input logic [31:0] ri,
                       input logic rd, input logic [63:0] rp, input logic ir);
    imem_req_ready = rdy; imem_rsp_valid = rsp; imem_rsp_insn = ri;
    redirect_valid = rd;  redirect_pc = rp;     i_ready = ir;
  endtask

  initial begin
    logic        pending, acc, prev_redir;
    logic [63:0] paddr, exp_pc, rp;
    int          pdelay, npops;

    // Directed cycle table: inputs for the cycle, outputs observed in it.
    add(1,0,32'h0,       0,64'h0,          0, 1,RPC,          0,64'h0,       32'h0);
    add(1,1,32'h1111_1111,0,64'h0,         0, 0,RPC+4,        0,64'h0,       32'h0);
    add(1,0,32'h0,       0,64'h0,          0, 1,RPC+4,        1,RPC,         32'h1111_1111);
    add(1,1,32'h2222_2222,0,64'h0,         0, 0,RPC+8,        1,RPC,         32'h1111_1111);
    add(1,0,32'h0,       0,64'h0,          0, 0,RPC+8,        1,RPC,         32'h1111_1111);
    add(1,0,32'h0,       0,64'h0,          1, 0,RPC+8,        1,RPC,         32'h1111_1111);
    add(1,0,32'h0,       0,64'h0,          0, 1,RPC+8,        1,RPC+4,       32'h2222_2222);
    add(1,1,32'h3333_3333,0,64'h0,         1, 0,RPC+12,       1,RPC+4,       32'h2222_2222);
    add(0,0,32'h0,       0,64'h0,          0, 1,RPC+12,       1,RPC+8,       32'h3333_3333);
    add(1,0,32'h0,       0,64'h0,          0, 1,RPC+12,       1,RPC+8,       32'h3333_3333);
    add(0,0,32'h0,       1,64'h8000_1000,  1, 0,RPC+16,       1,RPC+8,       32'h3333_3333);
    add(1,1,32'hdead_beef,0,64'h0,         1, 0,64'h8000_1000,0,64'h0,       32'h0);
    add(1,0,32'h0,       0,64'h0,          1, 1,64'h8000_1000,0,64'h0,       32'h0);
    add(1,1,32'h4444_4444,1,64'h8000_2003, 1, 0,64'h8000_1004,0,64'h0,       32'h0);
    add(1,0,32'h0,       1,64'h8000_2800,  1, 1,64'h8000_2000,0,64'h0,       32'h0);
    add(1,0,32'h0,       1,64'h8000_3000,  0, 0,64'h8000_2800,0,64'h0,       32'h0);
    add(1,1,32'h5555_5555,0,64'h0,         0, 0,64'h8000_3000,0,64'h0,       32'h0);
    add(1,0,32'h0,       0,64'h0,          0, 1,64'h8000_3000,0,64'h0,       32'h0);
    add(1,1,32'h6666_6666,0,64'h0,         0, 0,64'h8000_3004,0,64'h0,       32'h0);
    add(0,0,32'h0,       1,64'h8000_4000,  1, 1,64'h8000_3004,1,64'h8000_3000,32'h6666_6666);
    add(0,0,32'h0,       0,64'h0,          1, 1,64'h8000_4000,0,64'h0,       32'h0);

    reset = 1'b1;
    drive(0,0,32'h0,0,64'h0,0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("rst_o_valid",   {63'h0, o_valid}, 64'h0);
    chk("rst_o_pc",      o_pc, 64'h0);
    chk("rst_o_insn",    {32'h0, o_insn}, 64'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rdy, vq[i].rsp, vq[i].rinsn, vq[i].redir, vq[i].rpc, vq[i].irdy);
      @(negedge clock);
      chk($sformatf("v%0d_req_valid", i), {63'h0, imem_req_valid}, {63'h0, vq[i].ev});
      chk($sformatf("v%0d_req_addr", i),  imem_req_addr, vq[i].ea);
      chk($sformatf("v%0d_o_valid", i),   {63'h0, o_valid}, {63'h0, vq[i].eov});
      chk($sformatf("v%0d_o_pc", i),      o_pc, vq[i].epc);
      chk($sformatf("v%0d_o_insn", i),    {32'h0, o_insn}, {32'h0, vq[i].eins});
      @(posedge clock); #1;
    end

    // Reset while a request is in flight with one entry queued.
    drive(1,0,32'h0,0,64'h0,0);
    @(posedge clock); #1;
    drive(0,1,32'h7777_7777,0,64'h0,0);
    @(posedge clock); #1;
    drive(1,0,32'h0,0,64'h0,0);
    @(posedge clock); #1;
    drive(0,0,32'h0,0,64'h0,0);
    @(negedge clock);
    chk("pre_rst_o_valid", {63'h0, o_valid}, 64'h1);
    chk("pre_rst_o_pc",    o_pc, 64'h8000_4000);
    chk("pre_rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_o_valid",   {63'h0, o_valid}, 64'h0);
    chk("mid_rst_o_pc",      o_pc, 64'h0);
    chk("mid_rst_o_insn",    {32'h0, o_insn}, 64'h0);
    chk("mid_rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("post_rst_req_addr",  imem_req_addr, RPC);
    chk("post_rst_o_valid",   {63'h0, o_valid}, 64'h0);

    // Random phase: memory with 1..4 cycle latency, random stalls and redirects.
    pending = 1'b0; acc = 1'b0; prev_redir = 1'b0;
    paddr = '0; pdelay = 0; npops = 0; exp_pc = RPC;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clock); #1;
      if (acc) begin
        pending = 1'b1;
        paddr   = imem_req_addr - 64'd4;
        pdelay  = $urandom_range(0, 3);
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_insn  = $urandom;
      if (pending) begin
        if (pdelay == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_insn  = mem_word(paddr);
          pending        = 1'b0;
        end else begin
          pdelay--;
        end
      end
      imem_req_ready = ($urandom_range(0, 3) != 0);
      i_ready        = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      rp = RPC + 64'({$urandom_range(0, 1023), 2'b00}) + 64'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 7));
      redirect_pc = redirect_valid ? rp : 64'($urandom);
      @(negedge clock);
      if (imem_req_valid)
        chk("rnd_one_outstanding", {63'h0, pending || imem_rsp_valid}, 64'h0);
      if (prev_redir)
        chk("rnd_flush_o_valid", {63'h0, o_valid}, 64'h0);
      if (!o_valid) begin
        if (o_pc != 64'h0 || o_insn != 32'h0)
          chk("rnd_empty_outputs", {o_insn, o_pc[31:0]}, 64'h0);
      end else if (i_ready && !redirect_valid) begin
        chk($sformatf("rnd_pop%0d_pc", npops), o_pc, exp_pc);
        chk($sformatf("rnd_pop%0d_insn", npops), {32'h0, o_insn}, {32'h0, mem_word(exp_pc)});
        exp_pc = exp_pc + 64'd4;
        npops++;
      end
      // imem_req_addr advances on acceptance, so remember the fired address.
      acc = imem_req_valid && imem_req_ready;
      if (acc && redirect_valid) begin
        pending = 1'b1;
        paddr   = imem_req_addr;
        pdelay  = $urandom_range(0, 3);
        acc     = 1'b0;
      end
      if (redirect_valid) exp_pc = redirect_pc & ~64'h3;
      prev_redir = redirect_valid;
    end
    chk("rnd_progress", {63'h0, npops >= 200}, 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
